// File: rtl/sum_window_framer.sv
// Window accumulator for the adder sum stream: saturating 16-bit total and max,
// emitted as a 4-byte frame over a byte-wide valid/ready port.
module sum_window_framer #(
    parameter int WINDOW = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       busy
);

    localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

    typedef enum logic {
        ACCUM,
        EMIT
    } state_e;

    state_e        state_q;
    logic [15:0]   acc_q;
    logic [7:0]    max_q;
    logic [CW-1:0] cnt_q;
    logic          sat_q;
    logic [1:0]    idx_q;

    logic [16:0]   sum_d;
    logic [15:0]   acc_d;
    logic          sat_d;
    logic [7:0]    max_d;

    // 17-bit sum exposes the carry that makes the total stick at 0xFFFF
    always_comb begin
        sum_d = {1'b0, acc_q} + {9'b0, s_data};
        acc_d = sum_d[16] ? 16'hFFFF : sum_d[15:0];
        sat_d = sat_q | sum_d[16];
        max_d = (s_data > max_q) ? s_data : max_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (s_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_d;
                        max_q <= max_d;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= EMIT;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if (idx_q == 2'd3) begin
                            state_q <= ACCUM;
                            acc_q   <= '0;
                            max_q   <= '0;
                            cnt_q   <= '0;
                            sat_q   <= 1'b0;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    // Outputs decode registered state only; no path from s_valid/m_ready
    always_comb begin
        s_ready = (state_q == ACCUM);
        m_valid = (state_q == EMIT);
        m_last  = 1'b0;
        m_data  = 8'h00;
        if (state_q == EMIT) begin
            m_last = (idx_q == 2'd3);
            unique case (idx_q)
                2'd0: m_data = {4'hA, 3'b000, sat_q};
                2'd1: m_data = acc_q[15:8];
                2'd2: m_data = acc_q[7:0];
                2'd3: m_data = max_q;
                default: m_data = 8'h00;
            endcase
        end
        busy = (state_q == EMIT) || (cnt_q != '0);
    end

endmodule

// File: tb/tb_sum_window_framer.sv
// Bench for sum_window_framer: table vectors, corner sequences and a
// randomized run against a window-level reference model.
module tb_sum_window_framer;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst_n, clear, s_valid, m_ready;
    logic [7:0] s_data;
    logic       s_ready, m_valid, m_last, busy;
    logic [7:0] m_data;

    logic       b_clear, b_s_valid, b_m_ready;
    logic [7:0] b_s_data;
    logic       b_s_ready, b_m_valid, b_m_last, b_busy;
    logic [7:0] b_m_data;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    sum_window_framer #(.WINDOW(W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
    );

    sum_window_framer #(.WINDOW(300)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .s_valid(b_s_valid), .s_data(b_s_data), .s_ready(b_s_ready),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .m_last(b_m_last), .busy(b_busy)
    );

    int         win[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic       got_last[$];

    typedef struct {
        logic [7:0]  start;
        logic [7:0]  stp;
        logic [31:0] frame;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame is a function of the whole window's samples
    task automatic push_frame();
        int tot = 0;
        int mx = 0;
        logic        sat;
        logic [15:0] a;
        foreach (win[i]) begin
            tot += win[i];
            if (win[i] > mx) mx = win[i];
        end
        sat = (tot > 65535);
        a   = sat ? 16'hFFFF : 16'(tot);
        exp_q.push_back({4'hA, 3'b000, sat});
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(8'(mx));
    endtask

    task automatic step();
        bit xs, xm;
        xs = rst_n && !clear && s_valid && s_ready;
        xm = rst_n && !clear && m_valid && m_ready;
        if (!rst_n || clear) begin
            win.delete();
            exp_q.delete();
        end else begin
            if (xm) begin
                got.push_back(m_data);
                got_last.push_back(m_last);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (xs) begin
                win.push_back(int'(s_data));
                if (win.size() == W) begin
                    push_frame();
                    win.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        chk("s_ready", 32'(s_ready), 32'(exp_q.size() == 0));
        chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        chk("m_data", 32'(m_data), 32'(exp_q.size() != 0 ? exp_q[0] : 8'h00));
        chk("m_last", 32'(m_last), 32'(exp_q.size() == 1));
        chk("busy", 32'(busy), 32'(exp_q.size() != 0 || win.size() != 0));
    endtask

    task automatic collect_check(string nm, logic [31:0] ef);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 12 && got.size() < 4; i++) step();
        chk({nm, "_len"}, 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("%s_b%0d", nm, b), 32'(got[b]), 32'(ef[31-8*b -: 8]));
                chk($sformatf("%s_last%0d", nm, b), 32'(got_last[b]), 32'(b == 3));
            end
        end
        got.delete();
        got_last.delete();
    endtask

    task automatic send_window(logic [7:0] start, logic [7:0] stp, logic mr);
        m_ready = mr;
        for (int i = 0; i < W; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(start + 8'(i) * stp);
            step();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] bp[8];
        int acc_n;
        logic [7:0] bb[$];

        tbl[0] = '{8'h01, 8'h01, 32'hA0008810};
        tbl[1] = '{8'h00, 8'h00, 32'hA0000000};
        tbl[2] = '{8'hFF, 8'h00, 32'hA00FF0FF};
        tbl[3] = '{8'h10, 8'h10, 32'hA00780F0};

        rst_n = 1'b0; clear = 1'b0; m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'h55;
        b_clear = 1'b0; b_s_valid = 1'b0; b_s_data = 8'h00; b_m_ready = 1'b0;
        step();
        step();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'h00);
        rst_n = 1'b1;
        s_valid = 1'b0;
        step();

        foreach (tbl[t]) begin
            send_window(tbl[t].start, tbl[t].stp, 1'b1);
            collect_check($sformatf("tbl%0d", t), tbl[t].frame);
        end

        // Backpressure: bytes held until taken, no input accepted meanwhile
        bp = '{0, 0, 1, 0, 1, 1, 0, 1};
        send_window(8'h01, 8'h01, 1'b0);
        foreach (bp[i]) begin
            s_valid = 1'b1;
            s_data  = 8'h77;
            m_ready = bp[i][0];
            step();
        end
        s_valid = 1'b0;
        collect_check("bp", 32'hA0008810);

        // Clear mid-window discards partial sum, including the clear-cycle sample
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'h40; step();
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        send_window(8'h02, 8'h00, 1'b1);
        collect_check("clrwin", 32'hA0002002);

        // Clear during byte 1 aborts the frame
        send_window(8'h01, 8'h01, 1'b0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("abort_byte1", 32'(m_data), 32'h00);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("abort_m_valid", 32'(m_valid), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd1);
        got.delete();
        got_last.delete();
        send_window(8'h01, 8'h01, 1'b1);
        collect_check("post_abort", 32'hA0008810);

        // Bubbles between zero samples
        m_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            s_valid = 1'b1; s_data = 8'h00; step();
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
            if (i < W - 1) chk("bubble_early", 32'(got.size()), 32'd0);
        end
        collect_check("bubble", 32'hA0000000);

        // Saturation on the WINDOW=300 instance
        acc_n = 0;
        b_s_valid = 1'b1; b_s_data = 8'hFF; b_m_ready = 1'b1;
        for (int i = 0; i < 400 && !b_m_valid; i++) begin
            if (b_s_ready) acc_n++;
            step();
        end
        b_s_valid = 1'b0;
        chk("sat_count", 32'(acc_n), 32'd300);
        for (int i = 0; i < 8 && bb.size() < 4; i++) begin
            if (b_m_valid) bb.push_back(b_m_data);
            step();
        end
        chk("sat_len", 32'(bb.size()), 32'd4);
        if (bb.size() == 4) begin
            chk("sat_b0", 32'(bb[0]), 32'hA1);
            chk("sat_b1", 32'(bb[1]), 32'hFF);
            chk("sat_b2", 32'(bb[2]), 32'hFF);
            chk("sat_b3", 32'(bb[3]), 32'hFF);
        end
        chk("sat_idle", 32'(b_m_valid), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom % 4) != 0;
            s_data  = 8'($urandom);
            m_ready = ($urandom % 3) != 0;
            clear   = ($urandom % 97) == 0;
            step();
        end
        clear = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sum_window_framer.md
# sum_window_framer

Downstream stage of the registered 8-bit adder output. Consumes the stream of 8-bit sums with a valid/ready handshake and accumulates WINDOW samples into a 16-bit saturating total while tracking the window maximum. It then emits a 4-byte result frame on a byte-wide valid/ready output for the pin driver or serializer that follows. Input is back-pressured while a frame is being emitted.

## Interface
- WINDOW, default 16: samples per window; legal range 2..1023.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous abort: drop the partial window or frame and restart accumulation.
- s_valid  in  1  input sample valid.
- s_data  in  8  input sample (unsigned sum from the adder stage).
- s_ready  out  1  block accepts a sample; a sample transfers when s_valid && s_ready at an edge.
- m_valid  out  1  frame byte valid.
- m_ready  in  1  downstream accepts the byte; it transfers when m_valid && m_ready at an edge.
- m_data  out  8  frame byte.
- m_last  out  1  high with the final byte (byte 3) of a frame.
- busy  out  1  high in EMIT, or in ACCUM when cnt != 0.

## Operation
- FSM has two states, ACCUM and EMIT. Reset and clear both go to ACCUM with acc=0, max=0, cnt=0, sat=0, idx=0.
- ACCUM state:
  - s_ready=1 and m_valid=0.
  - On each accepted sample: acc <= min(acc + s_data, 16'hFFFF). Use a 17-bit sum; if it exceeds 0xFFFF, the sticky sat bit is set.
  - max <= larger of max and s_data; cnt <= cnt+1.
  - Idle cycles (s_valid=0) do not count.
- When the sample accepted is the WINDOW-th (cnt == WINDOW-1), the FSM moves to EMIT. That sample is included in acc, max and sat.
- EMIT state:
  - s_ready=0 and m_valid=1.
  - Frame bytes by idx:
    - idx 0: {4'hA, 3'b000, sat}
    - idx 1: acc[15:8]
    - idx 2: acc[7:0]
    - idx 3: max
  - m_last = (idx==3).
  - idx advances on each transfer.
  - On transfer of byte 3: return to ACCUM with all state cleared.
- m_data and m_last hold stable while m_valid && !m_ready. In ACCUM, m_data=0x00 and m_last=0.
- clear is honoured in any state:
  - In EMIT it aborts the frame; m_valid drops the next cycle without byte 3. This is the only permitted valid-withdrawal.
  - A sample offered in the clear cycle is not accepted into the new window, even though s_ready may be 1.
- rst_n has priority over clear.

## Timing
- Reset values of all outputs: s_ready=1, m_valid=0, m_data=0x00, m_last=0, busy=0.
- s_ready, m_valid, m_data and m_last are decoded from registered state only. There is no combinational path from s_valid or m_ready to any output.
- Latency: WINDOW-th sample accepted at edge k → m_valid=1 with byte 0 in the cycle after edge k.
- Byte 3 transferred at edge j → s_ready=1 in the cycle after edge j. A new sample can be accepted at edge j+1.
- With m_ready held at 1, a frame occupies exactly 4 cycles. s_ready is low for exactly 4 cycles per window.
- Peak throughput: one window per WINDOW+4 cycles.
- Saturation: once sat=1, acc stays 0xFFFF for the rest of the window.

## Test plan
- Reset: rst_n low 2 cycles with s_valid=1, s_data=0x55 → s_ready=1, m_valid=0, busy=0. After release, the first frame reflects no 0x55 contribution.
- Basic frame (WINDOW=16): samples 1..16 back-to-back, m_ready=1 → bytes A0, 00, 88, 10. m_last only on 0x10. s_ready low for exactly 4 cycles.
- Saturation (instance with WINDOW=300): 300 samples of 0xFF → bytes A1, FF, FF, FF.
- Backpressure: m_ready pattern 0,0,1,0,1,1,0,1 during a frame → each byte held stable until transferred; order A0, 00, 88, 10 preserved; no input accepted meanwhile.
- Clear mid-window: 5 samples of 0x40, clear for 1 cycle, then 16 samples of 0x02 → bytes A0, 00, 20, 02. Also: clear during byte 1 → m_valid drops next cycle and accumulation restarts cleanly.
- Bubbles and zero data: 16 samples of 0x00 with s_valid gaps of 1-3 cycles → bytes A0, 00, 00, 00, emitted only after the 16th valid sample.
